// File: rtl/demux_tdm_1t4_if.sv
// Bundle for the four-slot TDM demultiplexer.
// Handshake: Din_valid alone qualifies a beat; there is no ready, the
// receiver accepts every valid beat on the same rising edge, and
// Frame_sync is only meaningful while Din_valid is high.
interface demux_tdm_1t4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] Din;
  logic             Din_valid;
  logic             Frame_sync;
  logic [WIDTH-1:0] O0;
  logic [WIDTH-1:0] O1;
  logic [WIDTH-1:0] O2;
  logic [WIDTH-1:0] O3;
  logic             Frame_valid;
  logic [1:0]       Slot;
  logic             Locked;
  logic             Sync_err;
  logic             State;   // debug view of the FSM: 0 = HUNT, 1 = RUN

  // Transmitter side: drives the serial stream, observes the demux.
  modport master (
    output Din, Din_valid, Frame_sync,
    input  O0, O1, O2, O3, Frame_valid, Slot, Locked, Sync_err, State
  );

  // Demux side.
  modport slave (
    input  Din, Din_valid, Frame_sync,
    output O0, O1, O2, O3, Frame_valid, Slot, Locked, Sync_err, State
  );
endinterface

// File: rtl/demux_tdm_1t4.sv
// Four-slot TDM demultiplexer: an internal slot counter, aligned by
// Frame_sync, spreads the serial beats over SH0..SH2; the slot-3 beat
// commits a whole frame to O0..O3 at once with a one-cycle Frame_valid.
module demux_tdm_1t4 #(
  parameter int WIDTH = 1
) (
  input logic                  clk,
  input logic                  rst,
  demux_tdm_1t4_if.slave       bus
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  // Slot FSM, shadow capture and atomic frame commit in one registered block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      o0          <= '0;
      o1          <= '0;
      o2          <= '0;
      o3          <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-raised below.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bus.Din_valid) begin
        case (state)
          HUNT: begin
            // Everything before the first sync is thrown away.
            if (bus.Frame_sync) begin
              sh0    <= bus.Din;
              slot   <= 2'd1;
              state  <= RUN;
              locked <= 1'b1;
            end
          end
          RUN: begin
            if (bus.Frame_sync && (slot != 2'd0)) begin
              // Misaligned sync: drop the partial frame, restart at slot 1.
              sync_err <= 1'b1;
              sh0      <= bus.Din;
              slot     <= 2'd1;
            end else begin
              case (slot)
                2'd0: sh0 <= bus.Din;
                2'd1: sh1 <= bus.Din;
                2'd2: sh2 <= bus.Din;
                default: begin
                  o0          <= sh0;
                  o1          <= sh1;
                  o2          <= sh2;
                  o3          <= bus.Din;
                  frame_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.O0          = o0;
  assign bus.O1          = o1;
  assign bus.O2          = o2;
  assign bus.O3          = o3;
  assign bus.Frame_valid = frame_valid;
  assign bus.Slot        = slot;
  assign bus.Locked      = locked;
  assign bus.Sync_err    = sync_err;
  assign bus.State       = state;

endmodule

// File: tb/tb_demux_tdm_1t4.sv
// Bench for demux_tdm_1t4 (WIDTH=4): a table of per-cycle vectors with
// hand-derived expectations, a frame scoreboard fed when a frame-closing
// beat is driven, and a randomized gapped-stream sequence.
module tb_demux_tdm_1t4;

  localparam int W = 4;

  logic clk;
  logic rst;

  demux_tdm_1t4_if #(.WIDTH(W)) bus ();

  demux_tdm_1t4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  din;
    logic        v;
    logic        s;
    logic [15:0] o;    // expected {O0,O1,O2,O3} after the edge
    logic        fv;
    logic [1:0]  slot;
    logic        lk;
    logic        se;
  } vec_t;

  vec_t vq[$];
  logic [4*W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] din, input logic v, input logic s,
                     input logic [15:0] o, input logic fv, input logic [1:0] slot,
                     input logic lk, input logic se);
    vec_t t;
    t.r = r; t.din = din; t.v = v; t.s = s;
    t.o = o; t.fv = fv; t.slot = slot; t.lk = lk; t.se = se;
    vq.push_back(t);
  endtask

  // Driver: apply inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic [3:0] din, input logic v, input logic s);
    @(negedge clk);
    rst            = r;
    bus.Din        = din;
    bus.Din_valid  = v;
    bus.Frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every Frame_valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (bus.Frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected act=%h%h%h%h exp=none", bus.O0, bus.O1, bus.O2, bus.O3);
      end else begin
        logic [4*W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_frame", {bus.O0, bus.O1, bus.O2, bus.O3}, e);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.Din        = '0;
    bus.Din_valid  = 1'b0;
    bus.Frame_sync = 1'b0;

    //   r  din  v  s  O0..O3    fv slot lk se
    // reset dominates a valid sync beat
    add(1, 4'hF, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(1, 4'hF, 1, 1, 16'h0000, 0, 0, 0, 0);
    // basic frame
    add(0, 4'hA, 1, 1, 16'h0000, 0, 1, 1, 0);
    add(0, 4'hB, 1, 0, 16'h0000, 0, 2, 1, 0);
    add(0, 4'hC, 1, 0, 16'h0000, 0, 3, 1, 0);
    add(0, 4'hD, 1, 0, 16'hABCD, 1, 0, 1, 0);
    add(0, 4'h0, 0, 0, 16'hABCD, 0, 0, 1, 0);
    // gaps and HUNT discard
    add(1, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 4'h1, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 4'h2, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 4'h3, 1, 1, 16'h0000, 0, 1, 1, 0);
    add(0, 4'h9, 0, 1, 16'h0000, 0, 1, 1, 0);
    add(0, 4'h9, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 4'h9, 0, 0, 16'h0000, 0, 1, 1, 0);
    add(0, 4'h4, 1, 0, 16'h0000, 0, 2, 1, 0);
    add(0, 4'h0, 0, 0, 16'h0000, 0, 2, 1, 0);
    add(0, 4'h5, 1, 0, 16'h0000, 0, 3, 1, 0);
    add(0, 4'h6, 1, 0, 16'h3456, 1, 0, 1, 0);
    add(0, 4'h0, 0, 0, 16'h3456, 0, 0, 1, 0);
    // free-running, sync on first beat only
    add(0, 4'h0, 1, 1, 16'h3456, 0, 1, 1, 0);
    add(0, 4'h1, 1, 0, 16'h3456, 0, 2, 1, 0);
    add(0, 4'h2, 1, 0, 16'h3456, 0, 3, 1, 0);
    add(0, 4'h3, 1, 0, 16'h0123, 1, 0, 1, 0);
    add(0, 4'h4, 1, 0, 16'h0123, 0, 1, 1, 0);
    add(0, 4'h5, 1, 0, 16'h0123, 0, 2, 1, 0);
    add(0, 4'h6, 1, 0, 16'h0123, 0, 3, 1, 0);
    add(0, 4'h7, 1, 0, 16'h4567, 1, 0, 1, 0);
    // misaligned sync at slot 2
    add(0, 4'h8, 1, 1, 16'h4567, 0, 1, 1, 0);
    add(0, 4'h9, 1, 0, 16'h4567, 0, 2, 1, 0);
    add(0, 4'hE, 1, 1, 16'h4567, 0, 1, 1, 1);
    add(0, 4'hF, 1, 0, 16'h4567, 0, 2, 1, 0);
    add(0, 4'h0, 1, 0, 16'h4567, 0, 3, 1, 0);
    add(0, 4'h1, 1, 0, 16'hEF01, 1, 0, 1, 0);
    // misaligned sync at slot 3 must not complete the frame
    add(0, 4'h2, 1, 1, 16'hEF01, 0, 1, 1, 0);
    add(0, 4'h3, 1, 0, 16'hEF01, 0, 2, 1, 0);
    add(0, 4'h4, 1, 0, 16'hEF01, 0, 3, 1, 0);
    add(0, 4'h5, 1, 1, 16'hEF01, 0, 1, 1, 1);
    add(0, 4'h6, 1, 0, 16'hEF01, 0, 2, 1, 0);
    add(0, 4'h7, 1, 0, 16'hEF01, 0, 3, 1, 0);
    add(0, 4'h8, 1, 0, 16'h5678, 1, 0, 1, 0);
    // reset mid-frame, then non-sync beats are discarded
    add(0, 4'h9, 1, 1, 16'h5678, 0, 1, 1, 0);
    add(0, 4'hA, 1, 0, 16'h5678, 0, 2, 1, 0);
    add(0, 4'hB, 1, 0, 16'h5678, 0, 3, 1, 0);
    add(1, 4'hC, 1, 1, 16'h0000, 0, 0, 0, 0);
    add(0, 4'hD, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 4'hE, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0);

    foreach (vq[i]) begin
      if (vq[i].fv) exp_q.push_back(vq[i].o);
      drive(vq[i].r, vq[i].din, vq[i].v, vq[i].s);
      chk($sformatf("v%0d_o", i), {bus.O0, bus.O1, bus.O2, bus.O3}, vq[i].o);
      chk($sformatf("v%0d_fv", i), 16'(bus.Frame_valid), 16'(vq[i].fv));
      chk($sformatf("v%0d_slot", i), 16'(bus.Slot), 16'(vq[i].slot));
      chk($sformatf("v%0d_locked", i), 16'(bus.Locked), 16'(vq[i].lk));
      chk($sformatf("v%0d_serr", i), 16'(bus.Sync_err), 16'(vq[i].se));
      chk($sformatf("v%0d_state", i), 16'(bus.State), 16'(vq[i].lk));
    end

    // Randomized gapped stream: one sync, then four free-running frames.
    drive(1, 4'h0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      logic [3:0] d [4];
      for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          drive(0, 4'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
          chk("rnd_gap_fv", 16'(bus.Frame_valid), 16'd0);
        end
        if (k == 3) exp_q.push_back({d[0], d[1], d[2], d[3]});
        drive(0, d[k], 1, (f == 0 && k == 0));
        chk("rnd_slot", 16'(bus.Slot), 16'((k + 1) % 4));
        chk("rnd_fv", 16'(bus.Frame_valid), 16'(k == 3));
      end
    end
    drive(0, 4'h0, 0, 0);
    drive(0, 4'h0, 0, 0);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
